// File: rtl/imm_gen_if.sv
// Valid/ready bus between the upstream fetch/decode logic and imm_gen_pipe.
// The master side offers instructions and consumes immediates. The slave side is the generator.
interface imm_gen_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) ();
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [2:0]       out_fmt;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_instr, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_tag
    );

    modport slave (
        input  in_valid, in_instr, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_tag
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// Registered RISC-V immediate generator with an optional skid register and a flush input.
// Decoding happens on the input side, so both holding registers store finished results.
module imm_gen_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5,
    parameter int unsigned SKID  = 1
) (
    input logic      clk,
    input logic      rst,
    input logic      flush,
    imm_gen_if.slave bus
);
    localparam logic [2:0] FmtNone = 3'd0;
    localparam logic [2:0] FmtI    = 3'd1;
    localparam logic [2:0] FmtS    = 3'd2;
    localparam logic [2:0] FmtB    = 3'd3;
    localparam logic [2:0] FmtU    = 3'd4;
    localparam logic [2:0] FmtJ    = 3'd5;
    localparam logic [2:0] FmtZ    = 3'd6;

    logic [31:0]      instr;
    logic [31:0]      dec_imm32;
    logic [2:0]       dec_fmt;
    logic [XLEN-1:0]  dec_imm;

    logic             main_valid_q, main_valid_d;
    logic [XLEN-1:0]  main_imm_q, main_imm_d;
    logic [2:0]       main_fmt_q, main_fmt_d;
    logic [TAG_W-1:0] main_tag_q, main_tag_d;
    logic             skid_valid_q, skid_valid_d;
    logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
    logic [2:0]       skid_fmt_q, skid_fmt_d;
    logic [TAG_W-1:0] skid_tag_q, skid_tag_d;

    logic in_ready;
    logic accept;
    logic consume;

    assign instr = bus.in_instr;

    always_comb begin
        dec_imm32 = 32'd0;
        dec_fmt   = FmtNone;
        unique case (instr[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: begin
                dec_imm32 = {{20{instr[31]}}, instr[31:20]};
                dec_fmt   = FmtI;
            end
            7'b0100011: begin
                dec_imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                dec_fmt   = FmtS;
            end
            7'b1100011: begin
                dec_imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                dec_fmt   = FmtB;
            end
            7'b0110111, 7'b0010111: begin
                dec_imm32 = {instr[31:12], 12'd0};
                dec_fmt   = FmtU;
            end
            7'b1101111: begin
                dec_imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21],
                             1'b0};
                dec_fmt   = FmtJ;
            end
            7'b1110011: begin
                if (instr[14]) begin
                    dec_imm32 = {27'd0, instr[19:15]};
                    dec_fmt   = FmtZ;
                end else if (instr[13:12] != 2'b00) begin
                    dec_imm32 = {{20{instr[31]}}, instr[31:20]};
                    dec_fmt   = FmtI;
                end
            end
            7'b0011011: begin
                if (XLEN == 64) begin
                    dec_imm32 = {{20{instr[31]}}, instr[31:20]};
                    dec_fmt   = FmtI;
                end
            end
            default: ;
        endcase
    end

    // Every format is either sign-extended from bit 31 or has bit 31 clear (Z, NONE).
    assign dec_imm = XLEN'($signed(dec_imm32));

    assign in_ready = (SKID != 0) ? (!skid_valid_q && !flush && !rst)
                                  : ((!main_valid_q || bus.out_ready) && !flush && !rst);
    assign accept   = bus.in_valid && in_ready;
    assign consume  = main_valid_q && bus.out_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        main_imm_d   = main_imm_q;
        main_fmt_d   = main_fmt_q;
        main_tag_d   = main_tag_q;
        skid_valid_d = skid_valid_q;
        skid_imm_d   = skid_imm_q;
        skid_fmt_d   = skid_fmt_q;
        skid_tag_d   = skid_tag_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (consume) begin
            if (skid_valid_q) begin
                main_imm_d   = skid_imm_q;
                main_fmt_d   = skid_fmt_q;
                main_tag_d   = skid_tag_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_imm_d   = dec_imm;
                main_fmt_d   = dec_fmt;
                main_tag_d   = bus.in_tag;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!main_valid_q) begin
                main_valid_d = 1'b1;
                main_imm_d   = dec_imm;
                main_fmt_d   = dec_fmt;
                main_tag_d   = bus.in_tag;
            end else begin
                // Only reachable with SKID=1: main is stalled, so park the entry behind it.
                skid_valid_d = 1'b1;
                skid_imm_d   = dec_imm;
                skid_fmt_d   = dec_fmt;
                skid_tag_d   = bus.in_tag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_imm_q   <= '0;
            main_fmt_q   <= FmtNone;
            main_tag_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_fmt_q   <= FmtNone;
            skid_tag_q   <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_imm_q   <= main_imm_d;
            main_fmt_q   <= main_fmt_d;
            main_tag_q   <= main_tag_d;
            skid_valid_q <= skid_valid_d;
            skid_imm_q   <= skid_imm_d;
            skid_fmt_q   <= skid_fmt_d;
            skid_tag_q   <= skid_tag_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = main_valid_q;
    assign bus.out_imm   = main_imm_q;
    assign bus.out_fmt   = main_fmt_q;
    assign bus.out_tag   = main_tag_q;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: XLEN=32 and XLEN=64 with skid, plus XLEN=32 without skid,
// all driven from the same stimulus.
module tb_imm_gen_pipe;
    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [4:0]  in_tag;
    logic        out_ready;

    int checks = 0;
    int errors = 0;

    imm_gen_if #(.XLEN(32), .TAG_W(5)) bus32 ();
    imm_gen_if #(.XLEN(64), .TAG_W(5)) bus64 ();
    imm_gen_if #(.XLEN(32), .TAG_W(5)) bus0 ();

    assign bus32.in_valid  = in_valid;
    assign bus32.in_instr  = in_instr;
    assign bus32.in_tag    = in_tag;
    assign bus32.out_ready = out_ready;
    assign bus64.in_valid  = in_valid;
    assign bus64.in_instr  = in_instr;
    assign bus64.in_tag    = in_tag;
    assign bus64.out_ready = out_ready;
    assign bus0.in_valid   = in_valid;
    assign bus0.in_instr   = in_instr;
    assign bus0.in_tag     = in_tag;
    assign bus0.out_ready  = out_ready;

    imm_gen_pipe #(.XLEN(32), .TAG_W(5), .SKID(1)) dut32 (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(5), .SKID(1)) dut64 (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus64)
    );

    imm_gen_pipe #(.XLEN(32), .TAG_W(5), .SKID(0)) dut0 (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled there too.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [63:0] imm32;
        logic [2:0]  fmt32;
        logic [63:0] imm64;
        logic [2:0]  fmt64;
    } vec_t;

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{32'h00A50293, 64'h0000_000A, 3'd1, 64'h0000_0000_0000_000A, 3'd1};
        vecs[1]  = '{32'h00208463, 64'h0000_0008, 3'd3, 64'h0000_0000_0000_0008, 3'd3};
        vecs[2]  = '{32'h12345537, 64'h1234_5000, 3'd4, 64'h0000_0000_1234_5000, 3'd4};
        vecs[3]  = '{32'h0100006F, 64'h0000_0010, 3'd5, 64'h0000_0000_0000_0010, 3'd5};
        vecs[4]  = '{32'hFFF00093, 64'hFFFF_FFFF, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1};
        vecs[5]  = '{32'h80000037, 64'h8000_0000, 3'd4, 64'hFFFF_FFFF_8000_0000, 3'd4};
        vecs[6]  = '{32'h3002D073, 64'h0000_0005, 3'd6, 64'h0000_0000_0000_0005, 3'd6};
        vecs[7]  = '{32'h00000000, 64'h0000_0000, 3'd0, 64'h0000_0000_0000_0000, 3'd0};
        vecs[8]  = '{32'h0000001B, 64'h0000_0000, 3'd0, 64'h0000_0000_0000_0000, 3'd1};
        vecs[9]  = '{32'hFE112E23, 64'hFFFF_FFFC, 3'd2, 64'hFFFF_FFFF_FFFF_FFFC, 3'd2};
        vecs[10] = '{32'h30002573, 64'h0000_0300, 3'd1, 64'h0000_0000_0000_0300, 3'd1};
        vecs[11] = '{32'h00000073, 64'h0000_0000, 3'd0, 64'h0000_0000_0000_0000, 3'd0};

        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'd0;
        in_tag    = 5'd0;
        out_ready = 1'b0;
        #1;
        chk("rst_in_ready", 64'(bus32.in_ready), 64'd0);
        cyc();
        cyc();
        chk("rst_out_valid", 64'(bus32.out_valid), 64'd0);
        chk("rst_out_imm", 64'(bus64.out_imm), 64'd0);
        chk("rst_out_fmt", 64'(bus32.out_fmt), 64'd0);
        chk("rst_out_tag", 64'(bus32.out_tag), 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(bus32.in_ready), 64'd1);

        // Streaming: every accepted vector shows up right after its accept edge.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int k = 0; k < 12; k++) begin
            in_instr = vecs[k].instr;
            in_tag   = 5'(k + 1);
            cyc();
            chk($sformatf("v%0d_valid", k), 64'(bus32.out_valid), 64'd1);
            chk($sformatf("v%0d_tag", k), 64'(bus32.out_tag), 64'(k + 1));
            chk($sformatf("v%0d_imm32", k), 64'(bus32.out_imm), vecs[k].imm32);
            chk($sformatf("v%0d_fmt32", k), 64'(bus32.out_fmt), 64'(vecs[k].fmt32));
            chk($sformatf("v%0d_imm64", k), bus64.out_imm, vecs[k].imm64);
            chk($sformatf("v%0d_fmt64", k), 64'(bus64.out_fmt), 64'(vecs[k].fmt64));
            chk($sformatf("v%0d_noskid_imm", k), 64'(bus0.out_imm), vecs[k].imm32);
            chk($sformatf("v%0d_noskid_tag", k), 64'(bus0.out_tag), 64'(k + 1));
        end
        in_valid = 1'b0;
        cyc();
        chk("drain_valid", 64'(bus32.out_valid), 64'd0);

        // Back-pressure: tags 1,2 fill main and skid, tag 3 must wait.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00100093;
        in_tag    = 5'd1;
        cyc();
        chk("bp_t1_tag", 64'(bus32.out_tag), 64'd1);
        chk("bp_t1_ready", 64'(bus32.in_ready), 64'd1);
        chk("bp_noskid_ready_stall", 64'(bus0.in_ready), 64'd0);
        in_instr = 32'h00200093;
        in_tag   = 5'd2;
        cyc();
        chk("bp_full_ready", 64'(bus32.in_ready), 64'd0);
        chk("bp_hold_tag", 64'(bus32.out_tag), 64'd1);
        in_instr = 32'h00300093;
        in_tag   = 5'd3;
        cyc();
        chk("bp_hold_tag2", 64'(bus32.out_tag), 64'd1);
        chk("bp_hold_imm", 64'(bus32.out_imm), 64'd1);
        out_ready = 1'b1;
        #1;
        chk("bp_skid_ready_registered", 64'(bus32.in_ready), 64'd0);
        chk("bp_noskid_ready_comb", 64'(bus0.in_ready), 64'd1);
        cyc();
        chk("bp_rel_t2_valid", 64'(bus32.out_valid), 64'd1);
        chk("bp_rel_t2_tag", 64'(bus32.out_tag), 64'd2);
        chk("bp_rel_t2_imm", 64'(bus32.out_imm), 64'd2);
        chk("bp_rel_ready", 64'(bus32.in_ready), 64'd1);
        cyc();
        chk("bp_t3_valid", 64'(bus32.out_valid), 64'd1);
        chk("bp_t3_tag", 64'(bus32.out_tag), 64'd3);
        in_valid = 1'b0;
        cyc();
        chk("bp_empty", 64'(bus32.out_valid), 64'd0);

        // Flush with two held entries and a simultaneous offer.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00400093;
        in_tag    = 5'd4;
        cyc();
        in_instr = 32'h00500093;
        in_tag   = 5'd5;
        cyc();
        flush    = 1'b1;
        in_instr = 32'h00600093;
        in_tag   = 5'd6;
        #1;
        chk("fl_in_ready", 64'(bus32.in_ready), 64'd0);
        cyc();
        flush = 1'b0;
        #1;
        chk("fl_out_valid", 64'(bus32.out_valid), 64'd0);
        chk("fl_ready_after", 64'(bus32.in_ready), 64'd1);
        cyc();
        chk("fl_t6_valid", 64'(bus32.out_valid), 64'd1);
        chk("fl_t6_tag", 64'(bus32.out_tag), 64'd6);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc();
        chk("fl_single_accept", 64'(bus32.out_valid), 64'd0);

        // Reset with main and skid full: nothing old may ever appear.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'hFFF00093;
        in_tag    = 5'd7;
        cyc();
        in_tag = 5'd8;
        cyc();
        rst    = 1'b1;
        in_tag = 5'd9;
        #1;
        chk("mr_in_ready", 64'(bus32.in_ready), 64'd0);
        cyc();
        chk("mr_valid", 64'(bus32.out_valid), 64'd0);
        chk("mr_imm", 64'(bus32.out_imm), 64'd0);
        chk("mr_imm64", bus64.out_imm, 64'd0);
        chk("mr_fmt", 64'(bus32.out_fmt), 64'd0);
        chk("mr_tag", 64'(bus32.out_tag), 64'd0);
        chk("mr_ready_held", 64'(bus32.in_ready), 64'd0);
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("mr_ready_release", 64'(bus32.in_ready), 64'd1);
        cyc();
        chk("mr_no_old_1", 64'(bus32.out_valid), 64'd0);
        cyc();
        chk("mr_no_old_2", 64'(bus32.out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
